// File: rtl/ctrl_encode_def.sv
// Shared encodings for the EX stage: ALUOp codes and multi-cycle ALU states.
package ctrl_encode_def;

   localparam int unsigned AluOpW = 5;

   localparam logic [AluOpW-1:0] AluOpAdd   = 5'd0;
   localparam logic [AluOpW-1:0] AluOpAddi  = 5'd1;
   localparam logic [AluOpW-1:0] AluOpAddu  = 5'd2;
   localparam logic [AluOpW-1:0] AluOpSub   = 5'd3;
   localparam logic [AluOpW-1:0] AluOpSubu  = 5'd4;
   localparam logic [AluOpW-1:0] AluOpSlt   = 5'd5;
   localparam logic [AluOpW-1:0] AluOpSltu  = 5'd6;
   localparam logic [AluOpW-1:0] AluOpAnd   = 5'd7;
   localparam logic [AluOpW-1:0] AluOpOr    = 5'd8;
   localparam logic [AluOpW-1:0] AluOpXor   = 5'd9;
   localparam logic [AluOpW-1:0] AluOpNor   = 5'd10;
   localparam logic [AluOpW-1:0] AluOpSll   = 5'd11;
   localparam logic [AluOpW-1:0] AluOpSrl   = 5'd12;
   localparam logic [AluOpW-1:0] AluOpSra   = 5'd13;
   localparam logic [AluOpW-1:0] AluOpLui   = 5'd14;
   localparam logic [AluOpW-1:0] AluOpBeq   = 5'd15;
   localparam logic [AluOpW-1:0] AluOpBne   = 5'd16;
   localparam logic [AluOpW-1:0] AluOpMfhi  = 5'd17;
   localparam logic [AluOpW-1:0] AluOpMflo  = 5'd18;
   localparam logic [AluOpW-1:0] AluOpMthi  = 5'd19;
   localparam logic [AluOpW-1:0] AluOpMtlo  = 5'd20;
   localparam logic [AluOpW-1:0] AluOpMult  = 5'd21;
   localparam logic [AluOpW-1:0] AluOpMultu = 5'd22;
   localparam logic [AluOpW-1:0] AluOpDiv   = 5'd23;
   localparam logic [AluOpW-1:0] AluOpDivu  = 5'd24;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StMdRun = 2'd1,
      StMdFix = 2'd2
   } md_state_e;

   function automatic logic is_long_op(input logic [AluOpW-1:0] op);
      return (op == AluOpMult) || (op == AluOpMultu) || (op == AluOpDiv) || (op == AluOpDivu);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: one shift-add or restoring-subtract step per cycle on magnitudes,
// with the sign fix-up applied combinationally on the final step.
module mdu_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_start,
   input  logic             i_is_div,
   input  logic             i_is_signed,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_run,
   output logic             o_last,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_den;
   logic [CntW-1:0]    r_cnt;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_b_zero;

   logic               w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH:0]     w_sum, w_shl, w_diff;
   logic [2*WIDTH-1:0] w_step, w_prod;
   logic [WIDTH-1:0]   w_q, w_r;

   assign w_a_neg = i_is_signed & i_a[WIDTH-1];
   assign w_b_neg = i_is_signed & i_b[WIDTH-1];
   assign w_a_mag = w_a_neg ? -i_a : i_a;
   assign w_b_mag = w_b_neg ? -i_b : i_b;

   // Multiply keeps the multiplier in the low half; divide keeps the quotient there.
   always_comb begin
      w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_den} : '0);
      w_shl  = r_acc[2*WIDTH-1:WIDTH-1];
      w_diff = w_shl - {1'b0, r_den};
      if (r_is_div) begin
         if (!w_diff[WIDTH]) w_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         else                w_step = {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end else begin
         w_step = {w_sum, r_acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      w_prod = r_neg_q ? -w_step : w_step;
      w_q    = w_step[WIDTH-1:0];
      w_r    = w_step[2*WIDTH-1:WIDTH];
      if (r_is_div) begin
         o_lo = r_b_zero ? '1 : (r_neg_q ? -w_q : w_q);
         o_hi = r_neg_r ? -w_r : w_r;
      end else begin
         o_lo = w_prod[WIDTH-1:0];
         o_hi = w_prod[2*WIDTH-1:WIDTH];
      end
   end

   assign o_last = i_run && (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_acc    <= '0;
         r_den    <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b_zero <= 1'b0;
      end else if (i_start) begin
         r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? w_a_mag : w_b_mag)};
         r_den    <= i_is_div ? w_b_mag : w_a_mag;
         r_cnt    <= CntW'(WIDTH - 1);
         r_is_div <= i_is_div;
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
         r_b_zero <= (i_b == '0);
      end else if (i_run) begin
         r_acc <= w_step;
         r_cnt <= r_cnt - CntW'(1);
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus iterative MULT/DIV into HI/LO,
// with a valid/ready request handshake.
module alu_mc
   import ctrl_encode_def::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy
);

   md_state_e        r_state, w_state_d;
   logic             r_init;
   logic [WIDTH-1:0] r_hi, r_lo, r_result;
   logic             r_zero, r_ovf, r_out_valid;

   logic             w_accept, w_long, w_md_start, w_md_last;
   logic [WIDTH-1:0] w_md_hi, w_md_lo;
   logic [WIDTH-1:0] w_add, w_sub, w_res;
   logic             w_ovf, w_hi_we, w_lo_we;
   logic [SHAMT_W-1:0] w_shamt;

   assign w_long     = is_long_op(op);
   assign w_accept   = in_valid && in_ready;
   assign w_md_start = w_accept && w_long;
   assign w_add      = a + b;
   assign w_sub      = a - b;
   assign w_shamt    = a[SHAMT_W-1:0];

   mdu_iter #(
      .WIDTH(WIDTH)
   ) u_mdu (
      .clk        (clk),
      .rstn       (rstn),
      .i_start    (w_md_start),
      .i_is_div   ((op == AluOpDiv) || (op == AluOpDivu)),
      .i_is_signed((op == AluOpMult) || (op == AluOpDiv)),
      .i_a        (a),
      .i_b        (b),
      .i_run      (r_state == StMdRun),
      .o_last     (w_md_last),
      .o_hi       (w_md_hi),
      .o_lo       (w_md_lo)
   );

   always_comb begin
      w_res   = '0;
      w_ovf   = 1'b0;
      w_hi_we = 1'b0;
      w_lo_we = 1'b0;
      case (op)
         AluOpAdd, AluOpAddi: begin
            w_res = w_add;
            w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
         end
         AluOpAddu: w_res = w_add;
         AluOpSub: begin
            w_res = w_sub;
            w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
         end
         AluOpSubu: w_res = w_sub;
         AluOpSlt:  w_res[0] = $signed(a) < $signed(b);
         AluOpSltu: w_res[0] = a < b;
         AluOpAnd:  w_res = a & b;
         AluOpOr:   w_res = a | b;
         AluOpXor:  w_res = a ^ b;
         AluOpNor:  w_res = ~(a | b);
         AluOpSll:  w_res = b << w_shamt;
         AluOpSrl:  w_res = b >> w_shamt;
         AluOpSra:  w_res = $unsigned($signed(b) >>> w_shamt);
         AluOpLui:  w_res = b << (WIDTH / 2);
         AluOpBeq:  w_res[0] = (a == b);
         AluOpBne:  w_res[0] = (a != b);
         AluOpMfhi: w_res = r_hi;
         AluOpMflo: w_res = r_lo;
         AluOpMthi: begin
            w_res   = a;
            w_hi_we = 1'b1;
         end
         AluOpMtlo: begin
            w_res   = a;
            w_lo_we = 1'b1;
         end
         default:   w_res = '0;
      endcase
   end

   // MD_FIX accepts like IDLE so the next op can issue in the completion cycle.
   always_comb begin
      w_state_d = r_state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      case (r_state)
         StIdle, StMdFix: begin
            in_ready  = r_init;
            w_state_d = w_md_start ? StMdRun : StIdle;
         end
         StMdRun: begin
            busy = 1'b1;
            if (w_md_last) w_state_d = StMdFix;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= StIdle;
         r_init      <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_init      <= 1'b1;
         r_out_valid <= 1'b0;
         if (w_md_last) begin
            r_hi        <= w_md_hi;
            r_lo        <= w_md_lo;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
         end else if (w_accept && !w_long) begin
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            if (w_hi_we) r_hi <= a;
            if (w_lo_we) r_lo <= a;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign overflow  = r_ovf;

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU for the MIPS datapath. It executes all single-cycle integer ops with a registered result, and adds an iterative multiply/divide unit with architectural HI/LO registers. A valid/ready handshake lets the pipeline stall on long ops. Sits in EX and replaces the purely combinational ALU; control supplies the 5-bit ALUOp codes from the shared encode package.

## Interface
- WIDTH, 32: operand/result width; must be even and at least 8.
- SHAMT_W, $clog2(WIDTH): shift-amount bits taken from `a`.
- clk  in  1  clock; all state changes on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; a transfer occurs when in_valid && in_ready.
- op  in  5  ALUOp code.
- a, b  in  WIDTH  operands (`a` is shift amount for shifts).
- out_valid  out  1  one-cycle pulse: result valid.
- result  out  WIDTH  operation result; held until next out_valid.
- zero  out  1  (result == 0), registered with result.
- overflow  out  1  signed overflow of ADD/ADDI/SUB, registered with result; 0 for all other ops.
- busy  out  1  multiply/divide in progress.

## Operation
- Single-cycle ops:
  - ADD, ADDI, ADDU: a+b mod 2^WIDTH.
  - SUB, SUBU: a−b.
  - SLT: signed a<b gives 1, else 0. SLTU: unsigned compare.
  - AND, OR, XOR, NOR.
  - SLL, SRL, SRA: b shifted by a[SHAMT_W-1:0].
  - LUI: b << (WIDTH/2).
  - BEQ: 1 if a==b else 0. BNE: 1 if a!=b else 0.
- HI/LO access:
  - MFHI, MFLO: result = HI, LO.
  - MTHI, MTLO: HI or LO = a; result = a.
- Long ops MULT, MULTU, DIV, DIVU:
  - Write HI/LO only; result = 0 with out_valid at completion.
  - Multiply: {HI,LO} = full 2·WIDTH product, signed or unsigned.
  - Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = a. No flag.
  - Signed MIN / −1: LO = MIN, HI = 0.
- Undefined op: result 0, overflow 0, out_valid still pulses.
- Overflow: set when the operand signs agree (ADD) or differ (SUB) and the result sign differs from `a`. The result is still written.
- State machine:
  - IDLE: in_ready=1. Single-cycle op → IDLE with output registered. Long op → MD_RUN, with count loaded WIDTH−1 and operands latched as magnitudes plus sign flags.
  - MD_RUN: busy=1, in_ready=0. One shift-add (multiply) or restore-subtract (divide) step per cycle. At count==0 → MD_FIX.
  - MD_FIX: apply sign correction, write HI/LO, pulse out_valid, then → IDLE.
- A single-cycle op accepted in IDLE while no long op is running uses the current HI/LO values. MFHI/MFLO issued during MD_RUN are not accepted (in_ready=0).

## Timing
- Reset (rstn=0 at edge): state=IDLE, HI=LO=0, result=0, zero=1, overflow=0, out_valid=0, busy=0, in_ready=0 in the reset cycle and 1 from the first cycle after release.
- Reset mid-operation aborts the op and leaves HI/LO=0. No out_valid is emitted for the aborted op.
- Single-cycle op latency: accepted at edge N, out_valid high during cycle N+1. Back-to-back issue is sustained at 1 op/cycle.
- Long op latency: accepted at edge N; MD_RUN occupies WIDTH cycles; MD_FIX one cycle; out_valid high in cycle N+WIDTH+1. in_ready returns high in that same cycle.
- A new op may be accepted in the out_valid cycle of a long op. MFHI/MFLO accepted then return the new HI/LO.
- in_valid while in_ready=0 is ignored; the requester must hold it.
- No backpressure on the output: the consumer must take result in the out_valid cycle.

## Structure
- Package ctrl_encode_def holds all ALUOp codes, including new MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO/SUB/SLTU/AND/XOR/NOR/SRL/SRA/LUI/BNE. It also holds the state encodings IDLE/MD_RUN/MD_FIX.
- Sub-module mdu_iter, parametrised by WIDTH, holds the counter, the partial-product/remainder register and the sign fix-up. alu_mc holds the decode, the single-cycle datapath, HI/LO and the output registers.

## Test plan
- ADD a=32'h7FFFFFFF, b=1 → result 32'h80000000, overflow=1, zero=0, out_valid one cycle after accept. ADDU with the same operands → overflow=0.
- SLT a=32'hFFFFFFFF, b=1 → result 1. SLTU with the same operands → 0. SRA a=4, b=32'h80000000 → 32'hF8000000.
- MULT a=−3, b=7 → out_valid at cycle N+33, in_ready=0 for cycles N+1..N+32. Then MFLO → 32'hFFFFFFEB and MFHI → 32'hFFFFFFFF.
- DIV a=−7, b=2 → LO=−3, HI=−1. DIVU a=7, b=0 → LO=32'hFFFFFFFF, HI=7. DIV 32'h80000000 / −1 → LO=32'h80000000, HI=0.
- Issue DIVU, then assert rstn=0 at cycle N+10 → no out_valid, HI=LO=0, in_ready=1 the cycle after release.
- Parameter sweep WIDTH=8 and 16: random MULT/MULTU/DIV/DIVU results checked against a reference model. Latency equals WIDTH+1.
